xgcd_perf_mon: RTL
==================

XGCD_PERF_MON -- requirements
Module: xgcd_perf_mon

Interface
REQ-001 SHALL have parameter CNT_W, default 32, the width of the cycle counter and the statistic registers (legal range 16..32).
REQ-002 SHALL have port clk_in_system, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have ports start_out_255 / done_out_255, input, 1 bit each: single-cycle start and done pulses from the 255-bit XGCD unit (channel 0).
REQ-005 SHALL have ports start_out_1279 / done_out_1279, input, 1 bit each: the same pulses from the 1279-bit unit (channel 1).
REQ-006 SHALL have APB slave input ports PADDR [31:0], PSEL, PENABLE, PWRITE and PWDATA [31:0].
REQ-007 SHALL have APB slave output ports PRDATA [31:0], PREADY and PSLVERR.
REQ-008 SHALL have port IRQ_PERF, output, 1 bit: the level interrupt raised on run completion.

Function
REQ-009 SHALL run one FSM per channel with states IDLE and RUN.
REQ-010 SHALL, in IDLE on start: set cnt=1 and go to RUN; done in IDLE SHALL be ignored.
REQ-011 SHALL, in RUN with no event: increment cnt, saturating at 2^CNT_W-1 and setting the sticky OVF bit on saturation.
REQ-012 SHALL, in RUN on done: LAST<=cnt; RUNS+=1, saturating; MIN<=min(MIN,cnt); MAX<=max(MAX,cnt); DONE sticky bit set; go to IDLE.
REQ-013 SHALL, in RUN on start without done (restart): ABORTS+=1, saturating; cnt=1; stay in RUN; LAST/MIN/MAX/RUNS unchanged.
REQ-014 SHALL, in RUN on simultaneous start and done: complete the run as in REQ-012, then cnt=1 and stay in RUN.
REQ-015 SHALL give LAST a value equal to the number of clock edges from the sampled start to the sampled done, so done one cycle after start gives LAST=1.
REQ-016 SHALL use the per-channel register map at base 0x00 (ch0) and 0x20 (ch1): +0x00 LAST, +0x04 MIN, +0x08 MAX, +0x0C RUNS, +0x10 ABORTS, +0x14 STATUS {bit2 OVF, bit1 DONE, bit0 busy}.
REQ-017 SHALL provide CTRL at 0x40, RW: bit0 IE0, bit1 IE1; bit8 CLR is write-only and self-clearing and reads as 0.
REQ-018 SHALL make STATUS bits 2:1 write-1-to-clear; busy is read-only.
REQ-019 SHALL, on a CLR write: zero LAST, RUNS, ABORTS and sticky bits in both channels; set MIN=all-ones and MAX=0; leave FSM state unchanged.
REQ-020 SHALL, for a same-cycle done and W1C of DONE, give set priority, so DONE=1.
REQ-021 SHALL drive IRQ_PERF = (DONE0&IE0)|(DONE1&IE1), registered, asserting 1 cycle after the done edge.
REQ-022 SHALL hold PREADY=1 always (zero wait states) and drive PRDATA combinationally while PSEL is high; registers narrower than 32 bits SHALL be zero-extended.
REQ-023 SHALL commit writes only when PSEL&PENABLE&PWRITE.
REQ-024 SHALL assert PSLVERR=1 in the access phase for an address outside 0x00-0x14, 0x20-0x34, 0x40 or for a misaligned address; writes to read-only or error addresses SHALL be dropped and error reads SHALL return 0.

Reset
REQ-025 SHALL, on reset: both FSMs to IDLE; cnt, LAST, MAX, RUNS, ABORTS, sticky bits, CTRL=0; MIN=all-ones; IRQ_PERF=0; PSLVERR=0.
REQ-026 SHALL let reset during RUN discard the run with no statistic update; a start in the first cycle after reset is accepted.

Configuration
REQ-027 SHALL, with XGCD_PERF_MINMAX_EN defined: implement the MIN/MAX registers and compare logic.
REQ-028 SHALL, without XGCD_PERF_MINMAX_EN: remove the MIN/MAX flops; offsets +0x04/+0x08 read 0, do not error, and ignore writes.

Structure
REQ-029 SHALL place the state enum, register offsets, STATUS/CTRL bit positions and the CNT_W default in package xgcd_perf_pkg.
REQ-030 SHALL implement per-channel FSM, counter and statistics in sub-module xgcd_perf_chan, instantiated twice; APB decode, CTRL and IRQ SHALL be in the top module.

Verification
REQ-031 SHALL cover: ch0 start at t, done at t+100 -> LAST=100, MIN=MAX=100, RUNS=1, DONE=1, IRQ_PERF=0 (IE0=0).
REQ-032 SHALL cover: IE1=1, ch1 runs of 40 then 25 cycles -> MIN=25, MAX=40, RUNS=2, IRQ_PERF high at the first done+1 cycle; W1C 0x2 to 0x34 -> IRQ_PERF low next cycle.
REQ-033 SHALL cover: ch0 start, start again 10 cycles later, done 5 cycles after that -> ABORTS=1, LAST=5, RUNS=1.
REQ-034 SHALL cover: CNT_W=16, run of 70000 cycles -> LAST=0xFFFF, OVF=1.
REQ-035 SHALL cover: start and done in the same cycle during RUN -> RUNS increments, busy stays 1; a read of 0x18 -> PSLVERR=1, PRDATA=0.
REQ-036 SHALL cover: reset asserted mid-run -> all registers at reset values, busy=0; with the macro undefined, reads of 0x04 and 0x24 return 0.

Source files
------------

// File: rtl/xgcd_perf_pkg.sv
// xgcd_perf_pkg: shared definitions for the XGCD performance monitor.
//   - chan_state_e : per-channel run FSM states
//   - OFF_*        : per-channel register offsets (channel 0 at 0x00, channel 1 at 0x20)
//   - CTRL_ADDR    : control register address
//   - STATUS_* / CTRL_* bit positions
//   - CNT_W_DEFAULT: default counter/statistic width
//   - addr_ok()    : APB address legality check (aligned and mapped)
package xgcd_perf_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } chan_state_e;

  localparam int CNT_W_DEFAULT = 32;

  localparam logic [4:0]  OFF_LAST   = 5'h00;
  localparam logic [4:0]  OFF_MIN    = 5'h04;
  localparam logic [4:0]  OFF_MAX    = 5'h08;
  localparam logic [4:0]  OFF_RUNS   = 5'h0C;
  localparam logic [4:0]  OFF_ABORTS = 5'h10;
  localparam logic [4:0]  OFF_STATUS = 5'h14;
  localparam logic [31:0] CH1_BASE   = 32'h0000_0020;
  localparam logic [31:0] CTRL_ADDR  = 32'h0000_0040;

  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_DONE_BIT = 1;
  localparam int STATUS_OVF_BIT  = 2;

  localparam int CTRL_IE0_BIT = 0;
  localparam int CTRL_IE1_BIT = 1;
  localparam int CTRL_CLR_BIT = 8;

  // Legal: word aligned, and either a channel register (0x00-0x14, 0x20-0x34) or CTRL.
  function automatic logic addr_ok(input logic [31:0] a);
    logic in_chan;
    in_chan = (a[31:6] == 26'd0) && (a[4:0] <= OFF_STATUS);
    return (a[1:0] == 2'b00) && (in_chan || (a == CTRL_ADDR));
  endfunction

endpackage

// File: rtl/xgcd_perf_chan.sv
// xgcd_perf_chan: one monitor channel -- run FSM, cycle counter and run statistics.
//   clk, srst           : clock, synchronous active-high reset
//   start, done         : single-cycle pulses from the XGCD unit
//   clr                 : clear statistics and sticky bits (FSM untouched)
//   w1c_done, w1c_ovf   : clear requests for the sticky DONE / OVF bits
//   last .. aborts      : statistic registers (min_val/max_val read 0 when disabled)
//   done_flag, ovf_flag : sticky status bits;  busy : FSM is in RUN
// Optional feature: define XGCD_PERF_MINMAX_EN to build the MIN/MAX registers.
module xgcd_perf_chan
  import xgcd_perf_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             start,
  input  logic             done,
  input  logic             clr,
  input  logic             w1c_done,
  input  logic             w1c_ovf,
  output logic [CNT_W-1:0] last,
  output logic [CNT_W-1:0] min_val,
  output logic [CNT_W-1:0] max_val,
  output logic [CNT_W-1:0] runs,
  output logic [CNT_W-1:0] aborts,
  output logic             done_flag,
  output logic             ovf_flag,
  output logic             busy
);
  localparam logic [CNT_W-1:0] ALL_ONES = '1;
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  chan_state_e      state_reg;
  logic [CNT_W-1:0] cnt_reg, last_reg, runs_reg, aborts_reg;
  logic             done_reg, ovf_reg;

  logic [CNT_W-1:0] cnt_inc_next, runs_inc_next, aborts_inc_next;
  logic             in_run, complete, restart, counting, ovf_hit;

  assign cnt_inc_next    = (cnt_reg == ALL_ONES)    ? cnt_reg    : cnt_reg + ONE;
  assign runs_inc_next   = (runs_reg == ALL_ONES)   ? runs_reg   : runs_reg + ONE;
  assign aborts_inc_next = (aborts_reg == ALL_ONES) ? aborts_reg : aborts_reg + ONE;

  assign in_run   = (state_reg == ST_RUN);
  assign complete = in_run && done;             // includes simultaneous start+done
  assign restart  = in_run && start && !done;   // abort of the current run
  assign counting = in_run && !start && !done;
  assign ovf_hit  = counting && (cnt_inc_next == ALL_ONES);

  always_ff @(posedge clk) begin
    if (srst) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      last_reg   <= '0;
      runs_reg   <= '0;
      aborts_reg <= '0;
      done_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
    end else begin
      if (state_reg == ST_IDLE) begin
        if (start) begin
          cnt_reg   <= ONE;
          state_reg <= ST_RUN;
        end
      end else begin
        if (start) begin
          cnt_reg <= ONE;
        end else if (done) begin
          state_reg <= ST_IDLE;
        end else begin
          cnt_reg <= cnt_inc_next;
        end
      end

      if (clr) begin
        last_reg   <= '0;
        runs_reg   <= '0;
        aborts_reg <= '0;
        done_reg   <= 1'b0;
        ovf_reg    <= 1'b0;
      end else begin
        if (complete) begin
          last_reg <= cnt_reg;
          runs_reg <= runs_inc_next;
        end
        if (restart) begin
          aborts_reg <= aborts_inc_next;
        end
        // A completion in the same cycle as a clear request wins.
        if (complete) begin
          done_reg <= 1'b1;
        end else if (w1c_done) begin
          done_reg <= 1'b0;
        end
        if (ovf_hit) begin
          ovf_reg <= 1'b1;
        end else if (w1c_ovf) begin
          ovf_reg <= 1'b0;
        end
      end
    end
  end

`ifdef XGCD_PERF_MINMAX_EN
  logic [CNT_W-1:0] min_reg, max_reg;

  always_ff @(posedge clk) begin
    if (srst || clr) begin
      min_reg <= ALL_ONES;
      max_reg <= '0;
    end else if (complete) begin
      if (cnt_reg < min_reg) min_reg <= cnt_reg;
      if (cnt_reg > max_reg) max_reg <= cnt_reg;
    end
  end

  assign min_val = min_reg;
  assign max_val = max_reg;
`else
  assign min_val = '0;
  assign max_val = '0;
`endif

  assign last      = last_reg;
  assign runs      = runs_reg;
  assign aborts    = aborts_reg;
  assign done_flag = done_reg;
  assign ovf_flag  = ovf_reg;
  assign busy      = in_run;

endmodule

// File: rtl/xgcd_perf_mon.sv
// xgcd_perf_mon: run-time monitor for the 255-bit (ch0) and 1279-bit (ch1) XGCD units.
//   clk_in_system, reset             : clock, synchronous active-high reset
//   start_out_255 / done_out_255     : ch0 start/done pulses
//   start_out_1279 / done_out_1279   : ch1 start/done pulses
//   PADDR..PWDATA / PRDATA..PSLVERR  : APB slave, zero wait states
//   IRQ_PERF                         : registered level interrupt (DONE0&IE0 | DONE1&IE1)
// Optional feature: define XGCD_PERF_MINMAX_EN to build the MIN/MAX registers.
module xgcd_perf_mon
  import xgcd_perf_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic        clk_in_system,
  input  logic        reset,
  input  logic        start_out_255,
  input  logic        done_out_255,
  input  logic        start_out_1279,
  input  logic        done_out_1279,
  input  logic [31:0] PADDR,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic        IRQ_PERF
);
  logic [1:0]       start_vec, done_vec, w1c_done, w1c_ovf;
  logic [1:0]       done_flags, ovf_flags, busy_flags;
  logic [CNT_W-1:0] last_arr [2];
  logic [CNT_W-1:0] min_arr [2];
  logic [CNT_W-1:0] max_arr [2];
  logic [CNT_W-1:0] runs_arr [2];
  logic [CNT_W-1:0] aborts_arr [2];

  logic [1:0]  ie_reg;
  logic        irq_reg;
  logic        addr_valid, ctrl_sel, ch_sel, wr_en, clr;
  logic [31:0] rd_data;
  logic [27:0] unused_pwdata;

  assign start_vec = {start_out_1279, start_out_255};
  assign done_vec  = {done_out_1279, done_out_255};

  assign addr_valid = addr_ok(PADDR);
  assign ctrl_sel   = (PADDR == CTRL_ADDR);
  assign ch_sel     = PADDR[5];
  assign wr_en      = PSEL && PENABLE && PWRITE && addr_valid;
  assign clr        = wr_en && ctrl_sel && PWDATA[CTRL_CLR_BIT];

  assign unused_pwdata = {PWDATA[31:9], PWDATA[7:3]};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      // Valid non-CTRL addresses are always channel registers.
      assign w1c_done[gi] = wr_en && !ctrl_sel && (ch_sel == 1'(gi)) &&
                            (PADDR[4:0] == OFF_STATUS) && PWDATA[STATUS_DONE_BIT];
      assign w1c_ovf[gi]  = wr_en && !ctrl_sel && (ch_sel == 1'(gi)) &&
                            (PADDR[4:0] == OFF_STATUS) && PWDATA[STATUS_OVF_BIT];

      xgcd_perf_chan #(.CNT_W(CNT_W)) u_chan (
        .clk       (clk_in_system),
        .srst      (reset),
        .start     (start_vec[gi]),
        .done      (done_vec[gi]),
        .clr       (clr),
        .w1c_done  (w1c_done[gi]),
        .w1c_ovf   (w1c_ovf[gi]),
        .last      (last_arr[gi]),
        .min_val   (min_arr[gi]),
        .max_val   (max_arr[gi]),
        .runs      (runs_arr[gi]),
        .aborts    (aborts_arr[gi]),
        .done_flag (done_flags[gi]),
        .ovf_flag  (ovf_flags[gi]),
        .busy      (busy_flags[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk_in_system) begin
    if (reset) begin
      ie_reg  <= 2'b00;
      irq_reg <= 1'b0;
    end else begin
      if (wr_en && ctrl_sel) begin
        ie_reg <= {PWDATA[CTRL_IE1_BIT], PWDATA[CTRL_IE0_BIT]};
      end
      irq_reg <= |(done_flags & ie_reg);
    end
  end

  always_comb begin
    rd_data = '0;
    if (ctrl_sel) begin
      rd_data[CTRL_IE0_BIT] = ie_reg[0];
      rd_data[CTRL_IE1_BIT] = ie_reg[1];
    end else begin
      case (PADDR[4:0])
        OFF_LAST:   rd_data = 32'(last_arr[ch_sel]);
        OFF_MIN:    rd_data = 32'(min_arr[ch_sel]);
        OFF_MAX:    rd_data = 32'(max_arr[ch_sel]);
        OFF_RUNS:   rd_data = 32'(runs_arr[ch_sel]);
        OFF_ABORTS: rd_data = 32'(aborts_arr[ch_sel]);
        OFF_STATUS: begin
          rd_data[STATUS_BUSY_BIT] = busy_flags[ch_sel];
          rd_data[STATUS_DONE_BIT] = done_flags[ch_sel];
          rd_data[STATUS_OVF_BIT]  = ovf_flags[ch_sel];
        end
        default:    rd_data = '0;
      endcase
    end
  end

  assign PRDATA   = (PSEL && addr_valid) ? rd_data : 32'd0;
  assign PREADY   = 1'b1;
  assign PSLVERR  = PSEL && PENABLE && !addr_valid;
  assign IRQ_PERF = irq_reg;

endmodule
